// File: rtl/note_player_if.sv
// Song-reader to note-player handshake: one note per new_note strobe,
// note_done pulses back when the note finishes.
interface note_player_if;
  logic       new_note;
  logic [5:0] note;
  logic [5:0] duration;
  logic       note_done;
  logic       busy;

  modport master (
    output new_note, note, duration,
    input  note_done, busy
  );

  modport slave (
    input  new_note, note, duration,
    output note_done, busy
  );
endinterface

// File: rtl/note_player.sv
// Plays one note at a time as a square wave at the codec sample rate,
// counting its length in beats and honouring play/pause.
module note_player #(
  parameter int                 ACC_W     = 22,
  parameter int                 STEP_W    = 20,
  parameter logic signed [15:0] AMPLITUDE = 16'sd8192
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic                     beat,
  input  logic                     generate_next_sample,
  output logic [5:0]               step_addr,
  input  logic [STEP_W-1:0]        step_in,
  output logic signed [15:0]       sample_out,
  output logic                     new_sample_ready,
  note_player_if.slave             song
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_PLAY = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [5:0]         step_addr_q, step_addr_d;
  logic [5:0]         remaining_q, remaining_d;
  logic [STEP_W-1:0]  step_reg_q, step_reg_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_sum;
  logic signed [15:0] sample_q, sample_d;
  logic               ready_q, ready_d;

  always_comb begin
    state_d     = state_q;
    step_addr_d = step_addr_q;
    remaining_d = remaining_q;
    step_reg_d  = step_reg_q;
    acc_d       = acc_q;
    sample_d    = sample_q;
    ready_d     = generate_next_sample;
    acc_sum     = acc_q + ACC_W'(step_reg_q);

    case (state_q)
      S_IDLE: begin
        if (song.new_note) begin
          step_addr_d = song.note;
          remaining_d = song.duration;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: state_d = S_LOAD;
      S_LOAD: begin
        step_reg_d = (step_addr_q == 6'd0) ? '0 : step_in;
        acc_d      = '0;
        state_d    = (remaining_q == 6'd0) ? S_DONE : S_PLAY;
      end
      S_PLAY: begin
        if (beat && play) begin
          remaining_d = remaining_q - 6'd1;
          if (remaining_q == 6'd1) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Sample path runs independently of the beat counter so a final beat
    // coinciding with a request still yields a PLAY-rule sample.
    if (generate_next_sample) begin
      if (state_q == S_PLAY && play) begin
        acc_d = acc_sum;
        if (step_reg_q == '0)
          sample_d = '0;
        else
          sample_d = acc_sum[ACC_W-1] ? -AMPLITUDE : AMPLITUDE;
      end else begin
        sample_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      step_addr_q <= '0;
      remaining_q <= '0;
      step_reg_q  <= '0;
      acc_q       <= '0;
      sample_q    <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_addr_q <= step_addr_d;
      remaining_q <= remaining_d;
      step_reg_q  <= step_reg_d;
      acc_q       <= acc_d;
      sample_q    <= sample_d;
      ready_q     <= ready_d;
    end
  end

  assign step_addr        = step_addr_q;
  assign sample_out       = sample_q;
  assign new_sample_ready = ready_q;
  assign song.note_done   = (state_q == S_DONE);
  assign song.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_note_player.sv
// Randomized scoreboard bench for note_player: a timeline model of each note
// queues expected samples and note_done cycles; a monitor pops and compares.
module tb_note_player;
  localparam int ACC_W  = 22;
  localparam int STEP_W = 20;
  localparam int MAXC   = 20000;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     play = 1'b0;
  logic                     beat = 1'b0;
  logic                     gen = 1'b0;
  logic [5:0]               step_addr;
  logic [STEP_W-1:0]        step_in = '0;
  logic signed [15:0]       sample_out;
  logic                     new_sample_ready;

  note_player_if np_if ();

  note_player #(
    .ACC_W     (ACC_W),
    .STEP_W    (STEP_W),
    .AMPLITUDE (16'sd8192)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .play                 (play),
    .beat                 (beat),
    .generate_next_sample (gen),
    .step_addr            (step_addr),
    .step_in              (step_in),
    .sample_out           (sample_out),
    .new_sample_ready     (new_sample_ready),
    .song                 (np_if.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] rom_fn(input logic [5:0] a);
    int unsigned v;
    if (a == 6'd10) return 20'h20000;
    v = int'(a) * 32'h1357 + 32'h0abc;
    return v[19:0];
  endfunction

  // registered frequency ROM
  always @(posedge clk) step_in <= rom_fn(step_addr);

  int                 vectors = 0;
  int                 miscompares = 0;
  int                 cyc = 0;
  logic signed [15:0] sq[$];
  int                 dq[$];
  bit                 exp_busy [0:MAXC-1];

  // reference timeline: m_k = cycles since the note was accepted
  bit          m_busy = 1'b0;
  int          m_k = 0;
  int          m_left = 0;
  int          m_done_at = -1;
  int unsigned m_phase = 0;
  int unsigned m_step = 0;

  task automatic drive(input logic b, g, p, nn, input logic [5:0] n, d);
    logic signed [15:0] s;
    @(posedge clk); #1;
    cyc++;
    beat = b; gen = g; play = p;
    np_if.new_note = nn; np_if.note = n; np_if.duration = d;
    if (g) begin
      s = '0;
      if (m_busy && m_k >= 3 && cyc != m_done_at && p) begin
        m_phase = (m_phase + m_step) & 32'h3FFFFF;
        if (m_step != 0) s = m_phase[21] ? -16'sd8192 : 16'sd8192;
      end
      sq.push_back(s);
    end
    if (!m_busy) begin
      if (nn) begin
        m_busy = 1'b1; m_k = 1; m_left = int'(d);
        m_step = (n == 6'd0) ? 0 : int'(rom_fn(n));
        m_phase = 0; m_done_at = -1;
      end
    end else if (cyc == m_done_at) begin
      m_busy = 1'b0;
    end else begin
      if (m_k == 2 && m_left == 0) begin
        m_done_at = cyc + 1; dq.push_back(cyc + 1);
      end else if (m_k >= 3 && b && p) begin
        m_left--;
        if (m_left == 0) begin
          m_done_at = cyc + 1; dq.push_back(cyc + 1);
        end
      end
      m_k++;
    end
    if (cyc + 1 < MAXC) exp_busy[cyc+1] = m_busy;
  endtask

  task automatic apply_reset(input int n);
    drive(1'b0, 1'b0, play, 1'b0, 6'd0, 6'd0);
    @(posedge clk); #1;
    cyc++;
    reset = 1'b0; beat = 1'b0; gen = 1'b0; np_if.new_note = 1'b0;
    sq.delete(); dq.delete(); m_busy = 1'b0; m_done_at = -1;
    repeat (n) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    cyc++;
    reset = 1'b1;
    exp_busy[cyc] = 1'b0; exp_busy[cyc+1] = 1'b0;
  endtask

  task automatic play_note(input logic [5:0] n, d, input int bper, input bit gall,
                           input int pause_at, pause_len, input bit spam);
    int cnt = 0, played = 0, paused = 0;
    logic b, g, p, nn;
    drive(1'b0, gall, 1'b1, 1'b1, n, d);
    while (m_busy && cnt < 600) begin
      cnt++;
      b  = (cnt % bper) == 0;
      p  = !(played >= pause_at && paused < pause_len);
      g  = gall ? 1'b1 : ($urandom_range(0, 2) == 0);
      nn = spam && ($urandom_range(0, 7) == 0);
      if (b) begin
        if (p) played++; else paused++;
      end
      drive(b, g, p, nn, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    end
    if (m_busy) begin
      vectors++; miscompares++;
      $display("FAIL timeout note=%0d got=busy exp=idle within 600 cycles", n);
      apply_reset(2);
    end
  endtask

  // monitor
  initial begin
    logic signed [15:0] es;
    int                 ed;
    forever begin
      @(negedge clk);
      if (!reset) begin
        vectors++;
        if (np_if.busy || np_if.note_done || new_sample_ready || sample_out != 0 || step_addr != 0) begin
          miscompares++;
          $display("FAIL reset_outputs cyc=%0d got busy=%b done=%b rdy=%b smp=%0d addr=%0d exp all 0",
                   cyc, np_if.busy, np_if.note_done, new_sample_ready, sample_out, step_addr);
        end
      end else begin
        vectors++;
        if (np_if.busy !== exp_busy[cyc]) begin
          miscompares++;
          $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, np_if.busy, exp_busy[cyc]);
        end
        if (new_sample_ready) begin
          vectors++;
          if (sq.size() == 0) begin
            miscompares++;
            $display("FAIL sample_extra cyc=%0d got=%0d exp=no pulse", cyc, sample_out);
          end else begin
            es = sq.pop_front();
            if (sample_out !== es) begin
              miscompares++;
              $display("FAIL sample cyc=%0d got=%0d exp=%0d", cyc, sample_out, es);
            end
          end
        end
        if (np_if.note_done) begin
          vectors++;
          if (dq.size() == 0) begin
            miscompares++;
            $display("FAIL note_done_extra cyc=%0d got=1 exp=0", cyc);
          end else begin
            ed = dq.pop_front();
            if (ed != cyc) begin
              miscompares++;
              $display("FAIL note_done_cycle got=%0d exp=%0d", cyc, ed);
            end
          end
        end else if (dq.size() > 0 && dq[0] == cyc) begin
          vectors++; miscompares++;
          ed = dq.pop_front();
          $display("FAIL note_done_missing cyc=%0d got=0 exp=1", cyc);
        end
      end
    end
  end

  initial begin
    np_if.new_note = 1'b0; np_if.note = '0; np_if.duration = '0;
    repeat (3) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1; cyc++;
    reset = 1'b1;
    exp_busy[cyc] = 1'b0; exp_busy[cyc+1] = 1'b0;

    // reset in the middle of a playing note
    drive(1'b0, 1'b0, 1'b1, 1'b1, 6'd5, 6'd6);
    for (int i = 1; i <= 30; i++)
      drive((i % 7) == 0, $urandom_range(0, 1) == 1, 1'b1, 1'b0, 6'd0, 6'd0);
    apply_reset(3);
    play_note(6'd5, 6'd3, 7, 1'b0, 0, 0, 1'b0);

    // basic note with a strobe every cycle
    play_note(6'd10, 6'd4, 20, 1'b1, 0, 0, 1'b0);
    // pause for three beats after the first
    play_note(6'd7, 6'd3, 10, 1'b0, 1, 3, 1'b0);
    // rest and zero-length notes
    play_note(6'd0, 6'd2, 9, 1'b1, 0, 0, 1'b0);
    play_note(6'd12, 6'd0, 5, 1'b1, 0, 0, 1'b0);

    // back-to-back stress with ignored new_note strobes during playback
    for (int i = 0; i < 12; i++) begin
      play_note(($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
                6'($urandom_range(0, 6)), $urandom_range(3, 12),
                $urandom_range(0, 1) == 1, $urandom_range(0, 2),
                $urandom_range(0, 2), 1'b1);
    end

    repeat (4) drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0);
    vectors++;
    if (sq.size() != 0 || dq.size() != 0) begin
      miscompares++;
      $display("FAIL drain got samples_left=%0d dones_left=%0d exp 0 and 0", sq.size(), dq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
